hms_timer: RTL

Parametrised successor to the fixed 5-minute countdown timer. It keeps the four-field hours/minutes/seconds/milliseconds time value, now with these additions:
- an internal prescaler, so it runs from any system clock;
- a loadable preset;
- countdown or stopwatch mode;
- pause/resume;
- explicit completion flags.

It sits between the board clock and the seven-segment/display formatting logic and drives the displayed time directly.

---
 rtl/hms_timer_pkg.sv | 23 ++
 rtl/hms_timer_ms_prescaler.sv | 32 +++
 rtl/hms_timer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hms_timer_pkg.sv
// Shared types and field limits for the hours/minutes/seconds/milliseconds timer.
package hms_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  localparam logic [MS_W-1:0]  MS_MAX  = 10'd999;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

endpackage

// File: rtl/hms_timer_ms_prescaler.sv
// Divides the system clock down to a one-cycle millisecond tick while enabled.
module ms_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = enable && (count_q == CW'(DIV - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tick ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/hms_timer.sv
// Countdown/stopwatch timer with h:m:s.ms fields, loadable preset, pause/resume
// and completion flags.
//   state | meaning
//   IDLE  | stopped, time shows preset (or last load)
//   RUN   | counting on each millisecond tick
//   PAUSE | frozen, prescaler phase retained
//   DONE  | reached zero or stopwatch limit, time held
module hms_timer
  import hms_timer_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int HOUR_W   = 6,
  parameter int MAX_HOUR = 63,
  parameter int DEF_HOUR = 0,
  parameter int DEF_MIN  = 5,
  parameter int DEF_SEC  = 0,
  parameter int DEF_MS   = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              load_i,
  input  logic              mode_i,
  input  logic [HOUR_W-1:0] load_hour_i,
  input  logic [MIN_W-1:0]  load_min_i,
  input  logic [SEC_W-1:0]  load_sec_i,
  input  logic [MS_W-1:0]   load_ms_i,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic [MS_W-1:0]   ml_o,
  output logic              running_o,
  output logic              done_o,
  output logic              expired_o
);

  localparam int DIV = CLK_HZ / 1000;
  localparam logic [HOUR_W-1:0] MAX_H      = HOUR_W'(MAX_HOUR);
  localparam logic [HOUR_W-1:0] DEF_HOUR_V = HOUR_W'(DEF_HOUR);
  localparam logic [MIN_W-1:0]  DEF_MIN_V  = MIN_W'(DEF_MIN);
  localparam logic [SEC_W-1:0]  DEF_SEC_V  = SEC_W'(DEF_SEC);
  localparam logic [MS_W-1:0]   DEF_MS_V   = MS_W'(DEF_MS);

  state_e state_q, state_d;
  logic mode_q, mode_d;
  logic running_q, running_d, done_q, done_d, expired_q, expired_d;
  logic [HOUR_W-1:0] hour_q, hour_d, pre_hour_q, pre_hour_d, src_hour;
  logic [MIN_W-1:0]  min_q, min_d, pre_min_q, pre_min_d, src_min;
  logic [SEC_W-1:0]  sec_q, sec_d, pre_sec_q, pre_sec_d, src_sec;
  logic [MS_W-1:0]   ms_q, ms_d, pre_ms_q, pre_ms_d, src_ms;
  logic [MS_W-1:0]   ld_ms;
  logic tick, presc_clear, hit, src_zero, src_limit;

  ms_prescaler #(.DIV(DIV)) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (presc_clear),
    .enable  (state_q == RUN),
    .tick    (tick)
  );

  // A start from DONE runs from the preset, so completion is judged on that value.
  assign src_hour = (state_q == DONE) ? pre_hour_q : hour_q;
  assign src_min  = (state_q == DONE) ? pre_min_q  : min_q;
  assign src_sec  = (state_q == DONE) ? pre_sec_q  : sec_q;
  assign src_ms   = (state_q == DONE) ? pre_ms_q   : ms_q;
  assign src_zero = ({src_hour, src_min, src_sec, src_ms} == '0);
  assign src_limit = (src_hour > MAX_H) ||
                     ((src_hour == MAX_H) && (src_min == MIN_MAX) &&
                      (src_sec == SEC_MAX) && (src_ms == MS_MAX));
  assign ld_ms = (load_ms_i > MS_MAX) ? MS_MAX : load_ms_i;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    ms_d        = ms_q;
    pre_hour_d  = pre_hour_q;
    pre_min_d   = pre_min_q;
    pre_sec_d   = pre_sec_q;
    pre_ms_d    = pre_ms_q;
    presc_clear = 1'b0;
    done_d      = 1'b0;
    hit         = 1'b0;

    if (state_q == RUN) begin
      if (tick) begin
        if (mode_q) begin
          if (ms_q != MS_MAX) ms_d = ms_q + MS_W'(1);
          else begin
            ms_d = '0;
            if (sec_q != SEC_MAX) sec_d = sec_q + SEC_W'(1);
            else begin
              sec_d = '0;
              if (min_q != MIN_MAX) min_d = min_q + MIN_W'(1);
              else begin
                min_d  = '0;
                hour_d = hour_q + HOUR_W'(1);
              end
            end
          end
          hit = (hour_d == MAX_H) && (min_d == MIN_MAX) &&
                (sec_d == SEC_MAX) && (ms_d == MS_MAX);
        end else begin
          if (ms_q != '0) ms_d = ms_q - MS_W'(1);
          else begin
            ms_d = MS_MAX;
            if (sec_q != '0) sec_d = sec_q - SEC_W'(1);
            else begin
              sec_d = SEC_MAX;
              if (min_q != '0) min_d = min_q - MIN_W'(1);
              else begin
                min_d  = MIN_MAX;
                hour_d = hour_q - HOUR_W'(1);
              end
            end
          end
          hit = ({hour_d, min_d, sec_d, ms_d} == '0);
        end
      end
      // Completion on the tick of the pause cycle still takes effect.
      if (hit) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (pause_i) begin
        state_d = PAUSE;
      end
    end else if (load_i) begin
      pre_hour_d  = load_hour_i;
      pre_min_d   = clamp59(load_min_i);
      pre_sec_d   = clamp59(load_sec_i);
      pre_ms_d    = ld_ms;
      hour_d      = load_hour_i;
      min_d       = clamp59(load_min_i);
      sec_d       = clamp59(load_sec_i);
      ms_d        = ld_ms;
      presc_clear = 1'b1;
      state_d     = IDLE;
    end else if (start_i) begin
      if (state_q == PAUSE) begin
        state_d = RUN;
      end else begin
        mode_d      = mode_i;
        presc_clear = 1'b1;
        hour_d      = src_hour;
        min_d       = src_min;
        sec_d       = src_sec;
        ms_d        = src_ms;
        if (mode_i ? src_limit : src_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      hour_q     <= DEF_HOUR_V;
      min_q      <= DEF_MIN_V;
      sec_q      <= DEF_SEC_V;
      ms_q       <= DEF_MS_V;
      pre_hour_q <= DEF_HOUR_V;
      pre_min_q  <= DEF_MIN_V;
      pre_sec_q  <= DEF_SEC_V;
      pre_ms_q   <= DEF_MS_V;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      ms_q       <= ms_d;
      pre_hour_q <= pre_hour_d;
      pre_min_q  <= pre_min_d;
      pre_sec_q  <= pre_sec_d;
      pre_ms_q   <= pre_ms_d;
      running_q  <= running_d;
      done_q     <= done_d;
      expired_q  <= expired_d;
    end
  end

  assign hour_o    = hour_q;
  assign min_o     = min_q;
  assign sec_o     = sec_q;
  assign ml_o      = ms_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule
